// File: rtl/fifo_serializer.sv
// fifo_serializer: consumer end of a show-ahead FIFO. Pops DATA_W-bit words
// and shifts them out one bit per accepted beat on a serial valid/ready link.
// Optional even-parity trailer beat when FIFO_SER_PARITY_EN is defined.
module fifo_serializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_val,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              fifo_read,
    output logic              ser_data,
    output logic              ser_val,
    output logic              ser_first,
    output logic              ser_last,
    input  logic              ser_ready,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef FIFO_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shifted;
    logic              head_bit;
    logic              frame_end;
`ifdef FIFO_SER_PARITY_EN
    logic              par, par_n;
`endif

    // State, shift register and bit counter; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef FIFO_SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
`ifdef FIFO_SER_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Next-state and link outputs; a pop on the final accepted beat reloads
    // the shift register directly so consecutive frames have no idle gap.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        cnt_n     = cnt;
`ifdef FIFO_SER_PARITY_EN
        par_n     = par;
`endif
        fifo_read = 1'b0;
        ser_data  = 1'b0;
        ser_val   = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        frame_end = 1'b0;
        busy      = (state != IDLE);
        head_bit  = (MSB_FIRST != 0) ? sreg[DATA_W-1] : sreg[0];
        shifted   = (MSB_FIRST != 0) ? {sreg[DATA_W-2:0], 1'b0}
                                     : {1'b0, sreg[DATA_W-1:1]};

        case (state)
            IDLE: begin
                fifo_read = fifo_val;
            end
            SHIFT: begin
                ser_val   = 1'b1;
                ser_data  = head_bit;
                ser_first = (cnt == '0);
`ifndef FIFO_SER_PARITY_EN
                ser_last  = (cnt == LAST_BIT);
`endif
                if (ser_ready) begin
                    sreg_n = shifted;
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
`ifdef FIFO_SER_PARITY_EN
                        state_n = PAR;
`else
                        frame_end = 1'b1;
`endif
                    end
                end
            end
`ifdef FIFO_SER_PARITY_EN
            PAR: begin
                ser_val   = 1'b1;
                ser_data  = par;
                ser_last  = 1'b1;
                frame_end = ser_ready;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        if (frame_end) begin
            fifo_read = fifo_val;
            state_n   = IDLE;
            cnt_n     = '0;
        end

        // The FIFO must not lose a word while this block is being reset.
        if (rst) begin
            fifo_read = 1'b0;
        end

        if (fifo_read) begin
            state_n = SHIFT;
            sreg_n  = fifo_out;
            cnt_n   = '0;
`ifdef FIFO_SER_PARITY_EN
            par_n   = ^fifo_out;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: drives an MSB-first and an LSB-first serializer from one
// queue-based FIFO model and checks the accepted beat stream against frames
// computed directly from the queued words.
`timescale 1ns/1ps
module tb_fifo_serializer;

    localparam int DW = 8;
`ifdef FIFO_SER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    typedef struct {
        logic d1;
        logic d0;
        logic first;
        logic last;
        int   at;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_val;
    logic [DW-1:0] fifo_out;
    logic          ser_ready;
    logic          fread_m, data_m, val_m, first_m, last_m, busy_m;
    logic          fread_l, data_l, val_l, first_l, last_l, busy_l;

    logic [DW-1:0] fq[$];
    beat_t         exp_q[$];
    beat_t         got[$];
    int            pops[$];
    int            cyc_cnt = 0;
    int            n_chk   = 0;
    int            n_fail  = 0;
    logic          s_fread, s_val, s_d1, s_d0, s_first, s_last;

    always #5 clk = ~clk;

    fifo_serializer #(.DATA_W(DW), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .fifo_val(fifo_val), .fifo_out(fifo_out),
        .fifo_read(fread_m), .ser_data(data_m), .ser_val(val_m),
        .ser_first(first_m), .ser_last(last_m), .ser_ready(ser_ready),
        .busy(busy_m)
    );

    fifo_serializer #(.DATA_W(DW), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .fifo_val(fifo_val), .fifo_out(fifo_out),
        .fifo_read(fread_l), .ser_data(data_l), .ser_val(val_l),
        .ser_first(first_l), .ser_last(last_l), .ser_ready(ser_ready),
        .busy(busy_l)
    );

    // Reference frame of one word: data bits in each order, then parity if enabled.
    function automatic void add_exp(input logic [DW-1:0] w);
        beat_t b;
        for (int i = 0; i < FL; i++) begin
            if (i < DW) begin
                b.d1 = w[DW-1-i];
                b.d0 = w[i];
            end else begin
                b.d1 = ^w;
                b.d0 = ^w;
            end
            b.first = (i == 0);
            b.last  = (i == FL - 1);
            b.at    = 0;
            exp_q.push_back(b);
        end
    endfunction

    task automatic clear_logs();
        got.delete();
        pops.delete();
        exp_q.delete();
    endtask

    task automatic fq_drive();
        if (fq.size() != 0) begin
            fifo_val = 1'b1;
            fifo_out = fq[0];
        end else begin
            fifo_val = 1'b0;
            fifo_out = DW'($urandom);
        end
    endtask

    // One clock: sample outputs mid-cycle, then log pops and accepted beats at the edge.
    task automatic step(input logic rdy);
        beat_t b;
        ser_ready = rdy;
        @(negedge clk);
        s_fread = fread_m;
        s_val   = val_m;
        s_d1    = data_m;
        s_d0    = data_l;
        s_first = first_m;
        s_last  = last_m;
        @(posedge clk);
        #1;
        if (s_fread && fifo_val) begin
            pops.push_back(cyc_cnt);
            if (fq.size() != 0) void'(fq.pop_front());
        end
        if (s_val && rdy) begin
            b.d1 = s_d1; b.d0 = s_d0; b.first = s_first; b.last = s_last; b.at = cyc_cnt;
            got.push_back(b);
        end
        cyc_cnt++;
        fq_drive();
    endtask

    task automatic drain(input int pct, output logic timeout);
        int n;
        n = 0;
        do begin
            step(($urandom_range(99) < pct) ? 1'b1 : 1'b0);
            n++;
        end while ((fq.size() != 0 || busy_m) && n < 3000);
        timeout = (fq.size() != 0 || busy_m);
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_ready = 1'b1; fifo_val = 1'b1; fifo_out = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({fread_m, fread_l} !== 2'b00) begin
            n_fail++; $display("FAIL reset_fifo_read got %b expected 00", {fread_m, fread_l});
        end
        n_chk++;
        if ({val_m, val_l, data_m, data_l} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_val_data got %b expected 0000", {val_m, val_l, data_m, data_l});
        end
        n_chk++;
        if ({first_m, first_l, last_m, last_l} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_first_last got %b expected 0000", {first_m, first_l, last_m, last_l});
        end
        n_chk++;
        if ({busy_m, busy_l} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy got %b expected 00", {busy_m, busy_l});
        end
        @(posedge clk); #1;
        rst = 1'b0; fifo_val = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({val_m, busy_m, fread_m} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset {val,busy,read} got %b expected 000", {val_m, busy_m, fread_m});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic          to;
        logic [DW-1:0] word;
        clear_logs();
        fq.push_back(8'hA5); add_exp(8'hA5); fq_drive();
        drain(100, to);
        n_chk++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b expected 0", to); end
        n_chk++;
        if (pops.size() != 1) begin n_fail++; $display("FAIL single_pops got %0d expected 1", pops.size()); end
        n_chk++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_beats got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if ({got[i].d1, got[i].d0, got[i].first, got[i].last} !==
                {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL single beat %0d {msb,lsb,first,last} got %b expected %b", i,
                         {got[i].d1, got[i].d0, got[i].first, got[i].last},
                         {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last});
            end
        end
        if (got.size() >= DW && pops.size() >= 1) begin
            word = '0;
            for (int i = 0; i < DW; i++) word = {word[DW-2:0], got[i].d1};
            n_chk++;
            if (word !== 8'hA5) begin n_fail++; $display("FAIL single_word got %h expected a5", word); end
            n_chk++;
            if (got[0].at != pops[0] + 1 || got[got.size()-1].at != got[0].at + FL - 1) begin
                n_fail++;
                $display("FAIL single_timing first/last beat cycle got %0d/%0d expected %0d/%0d",
                         got[0].at, got[got.size()-1].at, pops[0] + 1, pops[0] + FL);
            end
        end
        n_chk++;
        if ({busy_m, val_m} !== 2'b00) begin
            n_fail++; $display("FAIL single_end {busy,val} got %b expected 00", {busy_m, val_m});
        end
    endtask

    task automatic test_back_to_back();
        logic          to;
        logic [DW-1:0] w;
        int            nw;
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            if (pass == 0) begin
                fq.push_back(8'hFF); add_exp(8'hFF);
                fq.push_back(8'h00); add_exp(8'h00);
                nw = 2;
            end else begin
                nw = 6;
                for (int k = 0; k < nw; k++) begin
                    w = DW'($urandom); fq.push_back(w); add_exp(w);
                end
            end
            fq_drive();
            drain(100, to);
            n_chk++;
            if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout pass %0d got %b expected 0", pass, to); end
            n_chk++;
            if (pops.size() != nw) begin
                n_fail++; $display("FAIL b2b_pops pass %0d got %0d expected %0d", pass, pops.size(), nw);
            end
            n_chk++;
            if (got.size() != exp_q.size()) begin
                n_fail++; $display("FAIL b2b_beats pass %0d got %0d expected %0d", pass, got.size(), exp_q.size());
            end
            if (pops.size() >= 2 && got.size() >= FL) begin
                n_chk++;
                if (pops[1] != got[FL-1].at) begin
                    n_fail++; $display("FAIL b2b_second_pop cycle got %0d expected %0d", pops[1], got[FL-1].at);
                end
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_chk++;
                if ({got[i].d1, got[i].d0, got[i].first, got[i].last} !==
                    {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last} ||
                    got[i].at != got[0].at + i) begin
                    n_fail++;
                    $display("FAIL b2b beat %0d got %b at %0d expected %b at %0d", i,
                             {got[i].d1, got[i].d0, got[i].first, got[i].last}, got[i].at,
                             {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last}, got[0].at + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic          to;
        logic [DW-1:0] w;
        clear_logs();
        fq.push_back(8'h3C); add_exp(8'h3C);
        fq.push_back(8'h5A); add_exp(8'h5A);
        fq_drive();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            n_chk++;
            if ({s_fread, s_val, s_d1, s_d0, s_first, s_last} !== 6'b011100) begin
                n_fail++;
                $display("FAIL stall %0d {read,val,msb,lsb,first,last} got %b expected 011100",
                         k, {s_fread, s_val, s_d1, s_d0, s_first, s_last});
            end
        end
        n_chk++;
        if (got.size() != 2 || pops.size() != 1) begin
            n_fail++; $display("FAIL stall_progress beats/pops got %0d/%0d expected 2/1", got.size(), pops.size());
        end
        drain(100, to);
        n_chk++;
        if (to !== 1'b0 || pops.size() != 2) begin
            n_fail++; $display("FAIL bp_pops timeout/pops got %b/%0d expected 0/2", to, pops.size());
        end
        n_chk++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_beats got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if ({got[i].d1, got[i].d0, got[i].first, got[i].last} !==
                {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL bp beat %0d got %b expected %b", i,
                         {got[i].d1, got[i].d0, got[i].first, got[i].last},
                         {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last});
            end
        end
        // Random ready pattern over a longer random stream.
        clear_logs();
        for (int k = 0; k < 10; k++) begin
            w = DW'($urandom); fq.push_back(w); add_exp(w);
        end
        fq_drive();
        drain(60, to);
        n_chk++;
        if (to !== 1'b0 || pops.size() != 10) begin
            n_fail++; $display("FAIL rand_bp timeout/pops got %b/%0d expected 0/10", to, pops.size());
        end
        n_chk++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_bp_beats got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if ({got[i].d1, got[i].d0, got[i].first, got[i].last} !==
                {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL rand_bp beat %0d got %b expected %b", i,
                         {got[i].d1, got[i].d0, got[i].first, got[i].last},
                         {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last});
            end
        end
    endtask

    task automatic test_lsb_first();
        logic to;
        clear_logs();
        fq.push_back(8'h01); fq_drive();
        drain(100, to);
        n_chk++;
        if (to !== 1'b0 || got.size() != FL) begin
            n_fail++; $display("FAIL lsb_beats timeout/beats got %b/%0d expected 0/%0d", to, got.size(), FL);
        end
        for (int i = 0; i < DW && i < got.size(); i++) begin
            n_chk++;
            if ({got[i].d0, got[i].d1} !== {(i == 0) ? 1'b1 : 1'b0, (i == DW - 1) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL lsb_first beat %0d {lsb,msb} got %b expected %b", i, {got[i].d0, got[i].d1},
                         {(i == 0) ? 1'b1 : 1'b0, (i == DW - 1) ? 1'b1 : 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic to;
        clear_logs();
        fq.push_back(8'hC3); add_exp(8'hC3); fq_drive();
        step(1'b1);
        repeat (4) step(1'b1);
        fq.push_back(8'h81); fq_drive();
        rst = 1'b1;
        step(1'b0);
        n_chk++;
        if ({val_m, busy_m, val_l, busy_l} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_outputs {val,busy,val,busy} got %b expected 0000", {val_m, busy_m, val_l, busy_l});
        end
        n_chk++;
        if (pops.size() != 1 || got.size() != 4) begin
            n_fail++; $display("FAIL reset_mid_logs pops/beats got %0d/%0d expected 1/4", pops.size(), got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_chk++;
            if ({got[i].d1, got[i].d0} !== {exp_q[i].d1, exp_q[i].d0}) begin
                n_fail++; $display("FAIL reset_mid beat %0d got %b expected %b", i, {got[i].d1, got[i].d0}, {exp_q[i].d1, exp_q[i].d0});
            end
        end
        rst = 1'b0;
        clear_logs();
        add_exp(8'h81);
        drain(100, to);
        n_chk++;
        if (to !== 1'b0 || pops.size() != 1 || got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL after_reset timeout/pops/beats got %b/%0d/%0d expected 0/1/%0d", to, pops.size(), got.size(), FL);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if ({got[i].d1, got[i].d0, got[i].first, got[i].last} !==
                {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL after_reset beat %0d got %b expected %b", i,
                         {got[i].d1, got[i].d0, got[i].first, got[i].last},
                         {exp_q[i].d1, exp_q[i].d0, exp_q[i].first, exp_q[i].last});
            end
        end
    endtask

`ifdef FIFO_SER_PARITY_EN
    task automatic test_parity();
        logic to;
        clear_logs();
        fq.push_back(8'h07); fq.push_back(8'h03); fq_drive();
        drain(100, to);
        n_chk++;
        if (to !== 1'b0 || got.size() != 18) begin
            n_fail++; $display("FAIL parity_beats timeout/beats got %b/%0d expected 0/18", to, got.size());
        end
        if (got.size() == 18) begin
            n_chk++;
            if ({got[7].last, got[8].d1, got[8].d0, got[8].last, got[8].first} !== 5'b01110) begin
                n_fail++; $display("FAIL parity_frame1 got %b expected 01110",
                                   {got[7].last, got[8].d1, got[8].d0, got[8].last, got[8].first});
            end
            n_chk++;
            if ({got[17].d1, got[17].d0, got[17].last} !== 3'b001) begin
                n_fail++; $display("FAIL parity_frame2 got %b expected 001", {got[17].d1, got[17].d0, got[17].last});
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fifo_val = 1'b0; fifo_out = '0; ser_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_lsb_first();
        test_reset_mid();
`ifdef FIFO_SER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Consumer (read-side) end of the team's FIFO interface.
- Pops DATA_W-bit words from an upstream FIFO using its val / out / read handshake.
- Shifts each word out one bit per accepted beat on a serial valid/ready link.
- Sits between a FIFO and a serial link or packetizer, and drains the FIFO at the link's pace.

Parameters:
- DATA_W, 8: width of FIFO words. Must be ≥ 2.
- MSB_FIRST, 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous reset, active-high.
- fifo_val, input, 1: FIFO head word valid (show-ahead; fifo_out is meaningful whenever fifo_val=1).
- fifo_out, input, DATA_W: FIFO head word.
- fifo_read, output, 1: pop request; head consumed at the clk edge where fifo_read & fifo_val.
- ser_data, output, 1: current serial bit.
- ser_val, output, 1: ser_data valid.
- ser_first, output, 1: high while ser_data is the first bit of a word.
- ser_last, output, 1: high while ser_data is the final bit of a frame (data bit, or parity bit if enabled).
- ser_ready, input, 1: sink accepts the bit at edges where ser_val & ser_ready.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Interface is decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, shift register=0, bit counter=0.
  - Resulting outputs: ser_val=0, ser_data=0, ser_first=0, ser_last=0, busy=0, fifo_read=0.
  - Reset mid-word discards the remaining bits; no pop is issued in the reset cycle.
- FSM states: IDLE, SHIFT (and PAR when the optional feature is enabled).
- IDLE:
  - fifo_read = fifo_val (combinational).
  - On a pop edge: load shift register from fifo_out, counter=0, go to SHIFT.
- SHIFT:
  - ser_val=1. ser_data = shift-register MSB if MSB_FIRST=1, else its LSB.
  - ser_first = (counter==0). ser_last = (counter==DATA_W-1) when parity is disabled.
  - On accept: shift by one and increment the counter.
  - Accept of bit DATA_W-1 with parity disabled is the end of the frame.
- Back-to-back frames:
  - fifo_read = fifo_val during the cycle in which the end-of-frame beat is accepted.
  - If the pop occurs, the new word loads and the FSM stays in SHIFT with counter=0, so there is no idle bubble.
  - Otherwise the FSM goes to IDLE.
- fifo_read is never asserted outside IDLE or the end-of-frame accept cycle.
- Latency: pop at edge N; first bit valid from cycle N+1. Throughput is 1 bit/cycle with ser_ready held at 1.
- Backpressure: while ser_val=1 and ser_ready=0, ser_data, ser_first and ser_last hold, and the internal state holds.
- fifo_val is ignored while SHIFT is mid-word; the FIFO may fill, which is the intended backpressure path.
- Counter width is clog2(DATA_W+1) and it never wraps past DATA_W.

Optional Feature:
- Macro: FIFO_SER_PARITY_EN.
- Defined:
  - After data bit DATA_W-1 is accepted, the FSM enters PAR and presents the even-parity bit: XOR of the word, captured at load.
  - In PAR: ser_val=1, ser_last=1, ser_first=0. Data bit DATA_W-1 has ser_last=0.
  - The end-of-frame beat is the PAR accept; the back-to-back pop rule applies there.
  - Frame length is DATA_W+1 beats.
- Undefined: no PAR state and no parity logic; frame length is DATA_W beats.

Test Plan:
- Single word, no parity:
  - Stimulus: reset, then fifo_val=1 with fifo_out=8'hA5 for one pop, ser_ready=1.
  - Required: exactly one fifo_read pulse. Bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after the pop. ser_first on beat 0, ser_last on beat 7, then busy=0.
- Back-to-back:
  - Stimulus: FIFO holds 8'hFF then 8'h00, ser_ready=1.
  - Required: second pop in the same cycle as beat-7 accept. 16 contiguous valid beats (eight 1s then eight 0s), no gap.
- Backpressure:
  - Stimulus: send 8'h3C; drop ser_ready for 3 cycles at beat 2.
  - Required: ser_data=1 and ser_val=1 held stable for those 3 cycles. Frame completes with the correct bits. No extra fifo_read.
- LSB-first:
  - Stimulus: MSB_FIRST=0, word 8'h01.
  - Required: bit sequence 1,0,0,0,0,0,0,0.
- Reset mid-word:
  - Stimulus: assert rst at beat 4 of 8'hC3.
  - Required: next cycle ser_val=0 and busy=0. A subsequent word 8'h81 serializes cleanly from beat 0.
- Parity (FIFO_SER_PARITY_EN defined):
  - Stimulus: 8'h07, then 8'h03.
  - Required: 9th beat of the first frame = 1 with ser_last=1. 9th beat of the second frame = 0.
